// File: rtl/aoi_arb_pkg.sv
// Shared constants and operand layout for the round-robin AND-OR-INVERT arbiter.
package aoi_arb_pkg;

    localparam int          AOI_NREQ_DEFAULT = 4;
    localparam int unsigned AOI_OPW          = 4;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
    } aoi_op_t;

endpackage

// File: rtl/aoi_unit.sv
// Combinational AND-OR-INVERT cell: out = (a&b)|(c&d), out_n = ~out.
module aoi_unit (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic out,
    output logic out_n
);

    assign out   = (a & b) | (c & d);
    assign out_n = ~out;

endmodule

// File: rtl/aoi_arbiter.sv
// Round-robin arbiter sharing one aoi_unit among NREQ requesters, with a
// single-entry output register that reloads back-to-back on consume.
module aoi_arbiter
    import aoi_arb_pkg::*;
#(
    parameter int NREQ = AOI_NREQ_DEFAULT,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [AOI_OPW*NREQ-1:0] req_ops,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_out,
    output logic                    rsp_out_n,
    output logic [IDW-1:0]          rsp_id,
    output logic [7:0]              done_cnt
);

    localparam logic [0:0]  ST_EMPTY = 1'b0;
    localparam logic [0:0]  ST_FULL  = 1'b1;
    localparam int unsigned NREQ_U   = NREQ;

    logic [0:0]     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           out_q, out_d;
    logic           out_n_q, out_n_d;
    logic [IDW-1:0] id_q, id_d;
    logic [7:0]     cnt_q, cnt_d;

    aoi_op_t        ops_arr [NREQ];
    aoi_op_t        op_sel;
    logic           unit_out, unit_out_n;
    logic           grant_ok, consume, accept, gnt_found;
    logic [IDW-1:0] gnt_idx, idx_w;
    int unsigned    idx;

    assign consume  = (state_q == ST_FULL) && rsp_ready;
    // Reset gates the grant combinationally so req_ready is low on every reset cycle.
    assign grant_ok = rst_n && ((state_q == ST_EMPTY) || rsp_ready);

    always_comb begin
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            ops_arr[i] = req_ops[i*AOI_OPW +: AOI_OPW];
        end
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ_U) begin
                idx = idx - NREQ_U;
            end
            idx_w = IDW'(idx);
            if (!gnt_found && req_valid[idx_w]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx_w;
            end
        end
    end

    assign accept = grant_ok && gnt_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign op_sel = ops_arr[gnt_idx];

    aoi_unit u_aoi (
        .a     (op_sel.a),
        .b     (op_sel.b),
        .c     (op_sel.c),
        .d     (op_sel.d),
        .out   (unit_out),
        .out_n (unit_out_n)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        out_d   = out_q;
        out_n_d = out_n_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        if (consume) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = ST_EMPTY;
        end
        if (accept) begin
            state_d = ST_FULL;
            out_d   = unit_out;
            out_n_d = unit_out_n;
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            out_q   <= 1'b0;
            out_n_q <= 1'b1;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            out_n_q <= out_n_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_out   = out_q;
    assign rsp_out_n = out_n_q;
    assign rsp_id    = id_q;
    assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_aoi_arbiter.sv
// Directed self-checking bench for aoi_arbiter with NREQ=4.
module tb_aoi_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_ops;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_out;
    logic        rsp_out_n;
    logic [1:0]  rsp_id;
    logic [7:0]  done_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Per-requester results for OPS_MIX = {0101,1010,0011,1100}: r0=1 r1=1 r2=0 r3=0
    localparam logic [15:0] OPS_MIX = 16'h5A3C;
    logic [3:0] mix_res;

    aoi_arbiter #(.NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ops   (req_ops),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_out   (rsp_out),
        .rsp_out_n (rsp_out_n),
        .rsp_id    (rsp_id),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_ops   = OPS_MIX;
        rsp_ready = 1'b1;
        settle();
        chk("rst_ready_c0", req_ready, 4'b0000);
        tick();
        settle();
        chk("rst_ready_c1", req_ready, 4'b0000);
        tick();
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_out", rsp_out, 1'b0);
        chk("rst_out_n", rsp_out_n, 1'b1);
        chk("rst_id", rsp_id, 2'd0);
        chk("rst_done", done_cnt, 8'd0);
        rst_n     = 1'b1;
        req_valid = 4'b0000;
    endtask

    initial begin
        mix_res = 4'b0011;
        do_reset();

        // Single request from requester 2
        req_valid = 4'b0100;
        req_ops   = 16'h0C00;
        rsp_ready = 1'b1;
        settle();
        chk("single_ready", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        settle();
        chk("single_valid", rsp_valid, 1'b1);
        chk("single_out", rsp_out, 1'b1);
        chk("single_out_n", rsp_out_n, 1'b0);
        chk("single_id", rsp_id, 2'd2);
        chk("idle_ready", req_ready, 4'b0000);
        tick();
        chk("single_drain", rsp_valid, 1'b0);
        chk("single_done", done_cnt, 8'd1);

        // Fairness: all valid, consumer always ready, from ptr=0
        do_reset();
        req_ops   = OPS_MIX;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("fair_ready_%0d", k), req_ready, 4'b0001 << (k % 4));
            if (k > 0) begin
                chk($sformatf("fair_id_%0d", k), rsp_id, (k - 1) % 4);
                chk($sformatf("fair_out_%0d", k), rsp_out, mix_res[(k - 1) % 4]);
                chk($sformatf("fair_done_%0d", k), done_cnt, k - 1);
            end
            tick();
        end
        req_valid = 4'b0000;
        settle();
        chk("fair_id_5", rsp_id, 2'd0);
        chk("fair_ready_idle", req_ready, 4'b0000);
        tick();
        chk("fair_done_5", done_cnt, 8'd5);
        chk("fair_empty", rsp_valid, 1'b0);

        // Backpressure: ptr is 1, grant id 1 then stall for 3 cycles
        req_valid = 4'b0010;
        settle();
        chk("bp_grant1", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("bp_ready_%0d", k), req_ready, 4'b0000);
            chk($sformatf("bp_valid_%0d", k), rsp_valid, 1'b1);
            chk($sformatf("bp_id_%0d", k), rsp_id, 2'd1);
            chk($sformatf("bp_out_%0d", k), {rsp_out, rsp_out_n}, 2'b10);
            tick();
        end
        rsp_ready = 1'b1;
        settle();
        chk("bp_release", req_ready, 4'b0100);
        tick();
        chk("bp_id2", rsp_id, 2'd2);
        chk("bp_out2", {rsp_out, rsp_out_n}, 2'b01);
        chk("bp_done", done_cnt, 8'd6);

        // Mid-operation reset: full with ptr=3
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        settle();
        chk("mid_rst_ready", req_ready, 4'b0000);
        tick();
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_done", done_cnt, 8'd0);
        chk("mid_rst_out_n", rsp_out_n, 1'b1);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        settle();
        chk("mid_first_grant", req_ready, 4'b0001);
        tick();
        chk("mid_first_id", rsp_id, 2'd0);

        // Counter wrap: 257 consumes from reset
        do_reset();
        req_ops   = OPS_MIX;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c <= 257; c++) begin
            tick();
            if (c == 255) chk("wrap_255", done_cnt, 8'd255);
            if (c == 256) chk("wrap_256", done_cnt, 8'd0);
            if (c == 257) chk("wrap_257", done_cnt, 8'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
